mr_control_unit: RTL and testbench

- Control unit (FSM) for the Maquina Rudimentaria CPU.
- It consumes the instruction-register contents and the Z/N/V flag registers, and drives every datapath control strobe: IR/RDIR/PC loads, address mux, register-bank read select and write enable, RA load, ALU operate, flag loads, and memory write.
- It sits beside the datapath inside the cpu module and replaces the testbench-driven control regs.

---
 rtl/mr_control_unit_if.sv | 40 ++++
 rtl/mr_control_unit.sv | 146 ++++++++++++++
 tb/tb_mr_control_unit.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/mr_control_unit_if.sv
// Control interface between the Maquina Rudimentaria control unit and its datapath.
// The master side is the control unit: it reads the IR and the flags and drives every strobe.
// The slave side is the datapath, or a testbench standing in for it.
interface mr_control_unit_if #(
  parameter int IW = 16
);
  // Datapath state that the control unit observes
  logic [IW-1:0] ir;
  logic          rz;
  logic          rn;
  logic          rv;

  // Control strobes driven by the control unit
  logic          ld_ir;
  logic          ld_rdir;
  logic          ld_pc;
  logic          mux_1_pc;
  logic          reset_pc_sel;
  logic          mem_w;
  logic          Erd;
  logic          ld_ra;
  logic          operar_alu;
  logic          ld_rz;
  logic          ld_rn;
  logic          ld_rv;
  logic [1:0]    sel_Rf;
  logic [2:0]    state;

  modport master (
    input  ir, rz, rn, rv,
    output ld_ir, ld_rdir, ld_pc, mux_1_pc, reset_pc_sel, mem_w, Erd,
           ld_ra, operar_alu, ld_rz, ld_rn, ld_rv, sel_Rf, state
  );

  modport slave (
    output ir, rz, rn, rv,
    input  ld_ir, ld_rdir, ld_pc, mux_1_pc, reset_pc_sel, mem_w, Erd,
           ld_ra, operar_alu, ld_rz, ld_rn, ld_rv, sel_Rf, state
  );
endinterface

// File: rtl/mr_control_unit.sv
// Control unit FSM for the Maquina Rudimentaria CPU.
// Sequences fetch / decode / execute and drives all datapath strobes as a
// Moore machine, except in BRANCH where the condition decides the strobes.
// A taken branch merges the target fetch into the BRANCH cycle and jumps
// straight to DECODE.
module mr_control_unit #(
  parameter int IW = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  mr_control_unit_if.master  bus
);

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_LOAD   = 3'd3,
    ST_STORE  = 3'd4,
    ST_ALU    = 3'd5,
    ST_BRANCH = 3'd6
  } state_t;

  // Kept as a raw 3-bit vector so the unused encoding 7 is representable and recoverable
  logic [2:0] state_q;
  logic [2:0] state_d;
  logic [1:0] opcode;
  logic [2:0] cond;
  logic       branch_taken;
  logic       unused_inputs;

  assign opcode        = bus.ir[IW-1:IW-2];
  assign cond          = bus.ir[13:11];
  assign bus.state     = state_q;
  // V is reserved for future conditions and the low IR bits belong to the datapath
  assign unused_inputs = ^{bus.rv, bus.ir[10:0]};

  // Branch condition evaluated from the live flag registers
  always_comb begin
    branch_taken = 1'b0;
    case (cond)
      3'b000:  branch_taken = 1'b1;
      3'b001:  branch_taken = bus.rz;
      3'b010:  branch_taken = bus.rn;
      3'b011:  branch_taken = bus.rn | bus.rz;
      3'b100:  branch_taken = 1'b0;
      3'b101:  branch_taken = ~bus.rz;
      3'b110:  branch_taken = ~(bus.rn | bus.rz);
      3'b111:  branch_taken = ~bus.rn;
      default: branch_taken = 1'b0;
    endcase
  end

  // State register, asynchronously forced to RESET
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state sequencing; the illegal encoding falls back to RESET
  always_comb begin
    state_d = ST_RESET;
    case (state_q)
      ST_RESET:  state_d = ST_FETCH;
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: begin
        case (opcode)
          2'b00:   state_d = ST_LOAD;
          2'b01:   state_d = ST_STORE;
          2'b10:   state_d = ST_BRANCH;
          default: state_d = ST_ALU;
        endcase
      end
      ST_LOAD:   state_d = ST_FETCH;
      ST_STORE:  state_d = ST_FETCH;
      ST_ALU:    state_d = ST_FETCH;
      ST_BRANCH: state_d = branch_taken ? ST_DECODE : ST_FETCH;
      default:   state_d = ST_RESET;
    endcase
  end

  // Strobe decode; everything is gated off while reset is held so nothing fires mid-abort
  always_comb begin
    bus.ld_ir        = 1'b0;
    bus.ld_rdir      = 1'b0;
    bus.ld_pc        = 1'b0;
    bus.mux_1_pc     = 1'b0;
    bus.reset_pc_sel = 1'b0;
    bus.mem_w        = 1'b0;
    bus.Erd          = 1'b0;
    bus.ld_ra        = 1'b0;
    bus.operar_alu   = 1'b0;
    bus.ld_rz        = 1'b0;
    bus.ld_rn        = 1'b0;
    bus.ld_rv        = 1'b0;
    bus.sel_Rf       = 2'b00;
    if (rst_n) begin
      case (state_q)
        ST_RESET: begin
          bus.reset_pc_sel = 1'b1;
          bus.ld_pc        = 1'b1;
        end
        ST_FETCH: begin
          bus.ld_ir = 1'b1;
          bus.ld_pc = 1'b1;
        end
        ST_DECODE: begin
          bus.sel_Rf  = 2'b01;
          bus.ld_rdir = 1'b1;
          bus.ld_ra   = 1'b1;
        end
        ST_LOAD: begin
          bus.mux_1_pc = 1'b1;
          bus.Erd      = 1'b1;
          bus.ld_rz    = 1'b1;
          bus.ld_rn    = 1'b1;
        end
        ST_STORE: begin
          bus.mux_1_pc = 1'b1;
          bus.mem_w    = 1'b1;
        end
        ST_ALU: begin
          bus.sel_Rf     = 2'b10;
          bus.operar_alu = 1'b1;
          bus.Erd        = 1'b1;
          bus.ld_rz      = 1'b1;
          bus.ld_rn      = 1'b1;
          bus.ld_rv      = 1'b1;
        end
        ST_BRANCH: begin
          if (branch_taken) begin
            bus.mux_1_pc = 1'b1;
            bus.ld_ir    = 1'b1;
            bus.ld_pc    = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mr_control_unit.sv
// Self-checking bench for mr_control_unit.
// A small instruction-level model predicts the state trace and strobes of
// each instruction; random instructions and flags exercise it after the
// directed reset, load/store/alu, branch and recovery scenarios.
module tb_mr_control_unit;

  localparam int IW = 16;

  // Architectural state numbering
  localparam logic [2:0] M_RESET  = 3'd0;
  localparam logic [2:0] M_FETCH  = 3'd1;
  localparam logic [2:0] M_DECODE = 3'd2;
  localparam logic [2:0] M_LOAD   = 3'd3;
  localparam logic [2:0] M_STORE  = 3'd4;
  localparam logic [2:0] M_ALU    = 3'd5;
  localparam logic [2:0] M_BRANCH = 3'd6;

  // Bit positions inside the packed strobe vector
  localparam int P_LD_IR  = 13;
  localparam int P_LD_RDIR = 12;
  localparam int P_LD_PC  = 11;
  localparam int P_MUX    = 10;
  localparam int P_RPS    = 9;
  localparam int P_MEM_W  = 8;
  localparam int P_ERD    = 7;
  localparam int P_LD_RA  = 6;
  localparam int P_OP     = 5;
  localparam int P_LD_RZ  = 4;
  localparam int P_LD_RN  = 3;
  localparam int P_LD_RV  = 2;

  // Expected strobes for each kind of cycle, sel_Rf in bits 1:0
  localparam logic [13:0] S_NONE     = 14'd0;
  localparam logic [13:0] S_RESET    = 14'((1 << P_RPS) | (1 << P_LD_PC));
  localparam logic [13:0] S_FETCH    = 14'((1 << P_LD_IR) | (1 << P_LD_PC));
  localparam logic [13:0] S_DECODE   = 14'((1 << P_LD_RDIR) | (1 << P_LD_RA) | 1);
  localparam logic [13:0] S_LOAD     = 14'((1 << P_MUX) | (1 << P_ERD) | (1 << P_LD_RZ) | (1 << P_LD_RN));
  localparam logic [13:0] S_STORE    = 14'((1 << P_MUX) | (1 << P_MEM_W));
  localparam logic [13:0] S_ALU      = 14'((1 << P_OP) | (1 << P_ERD) | (1 << P_LD_RZ) | (1 << P_LD_RN) | (1 << P_LD_RV) | 2);
  localparam logic [13:0] S_BR_TAKEN = 14'((1 << P_MUX) | (1 << P_LD_IR) | (1 << P_LD_PC));

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  logic [2:0] mdl_state = M_RESET;

  mr_control_unit_if #(.IW(IW)) bus ();

  mr_control_unit #(.IW(IW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Hard stop in case the sequencing ever stalls
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [13:0] observed();
    return {bus.ld_ir, bus.ld_rdir, bus.ld_pc, bus.mux_1_pc, bus.reset_pc_sel,
            bus.mem_w, bus.Erd, bus.ld_ra, bus.operar_alu, bus.ld_rz,
            bus.ld_rn, bus.ld_rv, bus.sel_Rf};
  endfunction

  // Branch condition table written straight from the ISA definition
  function automatic logic taken(input logic [2:0] c, input logic z, input logic n);
    case (c)
      3'd0:    return 1'b1;
      3'd1:    return z;
      3'd2:    return n;
      3'd3:    return n || z;
      3'd4:    return 1'b0;
      3'd5:    return !z;
      3'd6:    return !(n || z);
      default: return !n;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic checkCycle(input string tag, input logic [2:0] exp_state, input logic [13:0] exp_strobes);
    checkOutput({tag, "/state"}, 16'(bus.state), 16'(exp_state));
    checkOutput({tag, "/strobes"}, 16'(observed()), 16'(exp_strobes));
    checkOutput({tag, "/memw_erd_excl"}, 16'(bus.mem_w & bus.Erd), 16'd0);
  endtask

  task automatic stepCycle(input string tag, input logic [2:0] exp_state, input logic [13:0] exp_strobes);
    @(posedge clk);
    #2;
    checkCycle(tag, exp_state, exp_strobes);
  endtask

  // Runs one instruction from FETCH or from a merged-fetch DECODE and checks every cycle
  task automatic applyStimulus(input logic [15:0] instr, input logic z, input logic n, input logic v);
    bus.ir = instr;
    bus.rz = z;
    bus.rn = n;
    bus.rv = v;
    if (mdl_state == M_FETCH) stepCycle("decode", M_DECODE, S_DECODE);
    case (instr[15:14])
      2'b00: begin
        stepCycle("load", M_LOAD, S_LOAD);
        stepCycle("load_next", M_FETCH, S_FETCH);
        mdl_state = M_FETCH;
      end
      2'b01: begin
        stepCycle("store", M_STORE, S_STORE);
        stepCycle("store_next", M_FETCH, S_FETCH);
        mdl_state = M_FETCH;
      end
      2'b11: begin
        stepCycle("alu", M_ALU, S_ALU);
        stepCycle("alu_next", M_FETCH, S_FETCH);
        mdl_state = M_FETCH;
      end
      default: begin
        if (taken(instr[13:11], z, n)) begin
          stepCycle("br_taken", M_BRANCH, S_BR_TAKEN);
          stepCycle("br_taken_next", M_DECODE, S_DECODE);
          mdl_state = M_DECODE;
        end else begin
          stepCycle("br_not_taken", M_BRANCH, S_NONE);
          stepCycle("br_not_taken_next", M_FETCH, S_FETCH);
          mdl_state = M_FETCH;
        end
      end
    endcase
  endtask

  initial begin
    bus.ir = '0;
    bus.rz = 1'b0;
    bus.rn = 1'b0;
    bus.rv = 1'b0;

    // Reset held for three cycles, then released away from the edge
    repeat (3) stepCycle("reset_hold", M_RESET, S_NONE);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkCycle("reset_release", M_RESET, S_RESET);
    stepCycle("first_fetch", M_FETCH, S_FETCH);
    mdl_state = M_FETCH;

    // Directed load, store, alu, and branch taken / not taken
    applyStimulus(16'h0000, 1'b0, 1'b0, 1'b0);
    applyStimulus(16'h4805, 1'b1, 1'b1, 1'b0);
    applyStimulus(16'hC8A4, 1'b0, 1'b1, 1'b1);
    applyStimulus(16'h8810, 1'b1, 1'b0, 1'b0);
    applyStimulus(16'h8810, 1'b0, 1'b0, 1'b0);

    // Every branch condition against every Z/N combination
    for (int c = 0; c < 8; c++) begin
      for (int f = 0; f < 4; f++) begin
        applyStimulus({2'b10, 3'(c), 11'h010}, f[0], f[1], 1'b0);
      end
    end

    // Reset in the middle of a store must drop mem_w before any clock edge
    if (mdl_state != M_FETCH) applyStimulus(16'h0000, 1'b0, 1'b0, 1'b0);
    applyStimulus(16'h0000, 1'b0, 1'b0, 1'b0);
    bus.ir = 16'h4805;
    stepCycle("mid_decode", M_DECODE, S_DECODE);
    stepCycle("mid_store", M_STORE, S_STORE);
    #1;
    rst_n = 1'b0;
    #1;
    checkCycle("mid_reset_abort", M_RESET, S_NONE);
    stepCycle("mid_reset_hold", M_RESET, S_NONE);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkCycle("mid_reset_release", M_RESET, S_RESET);
    stepCycle("mid_reset_fetch", M_FETCH, S_FETCH);
    mdl_state = M_FETCH;

    // Illegal encoding 7 recovers through RESET
    force dut.state_q = 3'd7;
    #1;
    checkCycle("illegal_state", 3'd7, S_NONE);
    release dut.state_q;
    stepCycle("illegal_recover", M_RESET, S_RESET);
    stepCycle("illegal_fetch", M_FETCH, S_FETCH);
    mdl_state = M_FETCH;

    // Random instruction stream with random flags
    repeat (150) begin
      applyStimulus(16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
